// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between two requesters.
// A round-robin grant picks one valid request, its operands and code are
// registered onto the ALU inputs, and the result is captured one cycle later.
// The captured result is then held on a response channel until it is consumed.
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   reqN_valid/ready              request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_code     operands and ALU code for requester N
//   alu_a, alu_b, alu_code        registered ALU inputs
//   alu_c, alu_overflow           ALU result (combinational from alu_*)
//   rsp_valid/ready               response handshake
//   rsp_id, rsp_c, rsp_overflow   captured requester id, result and overflow
//   ovf_sticky                    bit N set when a response to requester N overflowed
//   clr_ovf                       bit N clears ovf_sticky[N]; a same-cycle set wins
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [4:0]  req0_code,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [4:0]  req1_code,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_code,
  input  logic [15:0] alu_c,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_c,
  output logic        rsp_overflow,
  output logic [1:0]  ovf_sticky,
  input  logic [1:0]  clr_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic       last_grant;
  logic       id_q;
  logic       grant;
  logic       any_valid;
  logic [1:0] set_mask;

  // Contested requests go to whichever requester did not win last time.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
    else                          grant = 1'b0;
  end

  assign req0_ready = (state == IDLE) && !reset && any_valid && !grant;
  assign req1_ready = (state == IDLE) && !reset && any_valid &&  grant;

  always_comb begin
    set_mask = '0;
    if (state == EXEC && alu_overflow) set_mask[id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      id_q         <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_code     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_c        <= '0;
      rsp_overflow <= 1'b0;
      ovf_sticky   <= '0;
    end else begin
      // OR-ing the set after the clear makes a colliding set win.
      ovf_sticky <= (ovf_sticky & ~clr_ovf) | set_mask;
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_a      <= grant ? req1_a    : req0_a;
            alu_b      <= grant ? req1_b    : req0_b;
            alu_code   <= grant ? req1_code : req0_code;
            id_q       <= grant;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_c        <= alu_c;
          rsp_overflow <= alu_overflow;
          rsp_id       <= id_q;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives alu_c, and a
// transaction-level reference model predicts every DUT output each cycle.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_code, req1_code;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_code;
  logic        alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_overflow;
  logic [15:0] rsp_c;
  logic [1:0]  ovf_sticky, clr_ovf;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_code(req0_code),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_code(req1_code),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
    .alu_c(alu_c), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_overflow(rsp_overflow),
    .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Environment ALU: add, sub, equality; undefined codes give 0.
  always_comb begin
    alu_c = '0;
    alu_overflow = 1'b0;
    case (alu_code)
      5'b00000: begin
        alu_c = alu_a + alu_b;
        alu_overflow = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      5'b00001: begin
        alu_c = alu_a - alu_b;
        alu_overflow = (alu_a[15] != alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      5'b11100: alu_c = {15'd0, alu_a == alu_b};
      default: ;
    endcase
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU computed with integer arithmetic.
  task automatic ref_op(input logic [15:0] a, input logic [15:0] b, input logic [4:0] code,
                        output logic [15:0] c, output logic o);
    int s;
    c = '0;
    o = 1'b0;
    if (code == 5'd0 || code == 5'd1) begin
      s = (code == 5'd0) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
      c = s[15:0];
      o = (s > 32767) || (s < -32768);
    end else if (code == 5'd28) begin
      c = (a == b) ? 16'd1 : 16'd0;
    end
  endtask

  // Stimulus registers
  logic [1:0]  s_v = '0;
  logic [15:0] s_a [2];
  logic [15:0] s_b [2];
  logic [4:0]  s_code [2];
  logic        s_rst = 1'b1;
  logic        s_rspr = 1'b0;
  logic [1:0]  s_clr = '0;

  // Reference model: transaction phase 0 = free, 1 = executing, 2 = response held
  int unsigned m_busy;
  logic        m_known = 1'b0;
  logic        m_last, m_id, m_povf, m_rid, m_rovf;
  logic [15:0] m_pc, m_rc, m_a, m_b;
  logic [4:0]  m_code;
  logic [1:0]  m_sticky;
  logic        m_acc, m_acc_id;
  logic        d_acc, d_acc_id;

  task automatic model_reset();
    m_busy = 0; m_last = 1'b1; m_id = 1'b0; m_rc = '0; m_rid = 1'b0; m_rovf = 1'b0;
    m_a = '0; m_b = '0; m_code = '0; m_sticky = '0; m_acc = 1'b0;
  endtask

  task automatic step();
    logic e0, e1, id;
    logic [1:0] set;
    @(negedge clk);
    reset = s_rst; rsp_ready = s_rspr; clr_ovf = s_clr;
    req0_valid = s_v[0]; req0_a = s_a[0]; req0_b = s_b[0]; req0_code = s_code[0];
    req1_valid = s_v[1]; req1_a = s_a[1]; req1_b = s_b[1]; req1_code = s_code[1];
    #1;
    e0 = !s_rst && m_busy == 0 && s_v[0] && (!s_v[1] || m_last);
    e1 = !s_rst && m_busy == 0 && s_v[1] && (!s_v[0] || !m_last);
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    d_acc = (req0_ready && s_v[0]) || (req1_ready && s_v[1]);
    d_acc_id = req1_ready;
    if (m_known) begin
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy == 2));
      check("rsp_c", 32'(rsp_c), 32'(m_rc));
      check("rsp_id", 32'(rsp_id), 32'(m_rid));
      check("rsp_overflow", 32'(rsp_overflow), 32'(m_rovf));
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_code", 32'(alu_code), 32'(m_code));
      check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
    end
    m_acc = 1'b0;
    if (s_rst) begin
      model_reset();
      m_known = 1'b1;
    end else begin
      set = '0;
      if (m_busy == 2) begin
        if (s_rspr) m_busy = 0;
      end else if (m_busy == 1) begin
        m_rc = m_pc; m_rovf = m_povf; m_rid = m_id;
        set[m_id] = m_povf;
        m_busy = 2;
      end else if (e0 || e1) begin
        id = e1;
        m_a = s_a[id]; m_b = s_b[id]; m_code = s_code[id];
        ref_op(m_a, m_b, m_code, m_pc, m_povf);
        m_id = id; m_last = id; m_busy = 1;
        m_acc = 1'b1; m_acc_id = id;
      end
      m_sticky = (m_sticky & ~s_clr) | set;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_op(input int n);
    int unsigned k;
    k = $urandom_range(0, 3);
    s_code[n] = (k == 0) ? 5'd0 : (k == 1) ? 5'd1 : (k == 2) ? 5'd28 : 5'($urandom_range(0, 31));
    s_a[n] = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
    s_b[n] = ($urandom_range(0, 3) == 0) ? s_a[n] : 16'($urandom);
    s_v[n] = 1'b1;
  endtask

  task automatic do_reset();
    s_rst = 1'b1; s_v = '0; s_rspr = 1'b0; s_clr = '0;
    step(); step();
    s_rst = 1'b0;
  endtask

  logic        hold_id, hold_ovf;
  logic [15:0] hold_c;
  logic        order [4];
  int unsigned n_acc;

  initial begin
    for (int n = 0; n < 2; n++) begin s_a[n] = '0; s_b[n] = '0; s_code[n] = '0; end
    do_reset();

    // Signed add with overflow, then sticky clear
    s_v = 2'b01; s_a[0] = 16'h7F00; s_b[0] = 16'h0300; s_code[0] = 5'd0;
    step();
    check("add_accept", 32'(d_acc), 32'd1);
    s_v = '0;
    step();
    check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_rsp_c", 32'(rsp_c), 32'h8200);
    check("add_rsp_ovf", 32'(rsp_overflow), 32'd1);
    check("add_rsp_id", 32'(rsp_id), 32'd0);
    check("add_sticky", 32'(ovf_sticky), 32'd1);
    s_rspr = 1'b1; s_clr = 2'b01;
    step();
    check("clr_sticky", 32'(ovf_sticky), 32'd0);
    s_clr = '0;

    // Equality compares on requester 1
    for (int t = 0; t < 2; t++) begin
      s_v = 2'b10; s_a[1] = (t == 0) ? 16'h0705 : 16'h0804; s_b[1] = 16'h0705; s_code[1] = 5'b11100;
      step();
      s_v = '0; s_rspr = 1'b0;
      step();
      check("eq_rsp_c", 32'(rsp_c), (t == 0) ? 32'd1 : 32'd0);
      check("eq_rsp_id", 32'(rsp_id), 32'd1);
      s_rspr = 1'b1;
      step();
    end

    // Round robin from reset with both requesters always valid
    do_reset();
    s_v = 2'b11; s_rspr = 1'b1;
    s_a[0] = 16'h0001; s_b[0] = 16'h0002; s_code[0] = 5'd0;
    s_a[1] = 16'h0010; s_b[1] = 16'h0003; s_code[1] = 5'd1;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 4; i++) begin
      step();
      check("rr_one_hot", 32'(req0_ready && req1_ready), 32'd0);
      if (d_acc) begin order[n_acc] = d_acc_id; n_acc++; end
    end
    check("rr_count", 32'(n_acc), 32'd4);
    for (int i = 0; i < 4; i++) if (i < int'(n_acc)) check("rr_order", 32'(order[i]), 32'(i % 2));

    // Backpressure: response held while req1 waits
    do_reset();
    s_v = 2'b01; s_a[0] = 16'h8000; s_b[0] = 16'h8000; s_code[0] = 5'd0; s_rspr = 1'b0;
    step();
    s_v = 2'b10; s_a[1] = 16'h1234; s_b[1] = 16'h1234; s_code[1] = 5'd28;
    step();
    hold_c = rsp_c; hold_id = rsp_id; hold_ovf = rsp_overflow;
    check("bp_c", 32'(hold_c), 32'h0000);
    check("bp_ovf", 32'(hold_ovf), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_no_grant", 32'(d_acc), 32'd0);
      check("bp_hold", {15'd0, rsp_id, rsp_overflow, rsp_c}, {15'd0, hold_id, hold_ovf, hold_c});
    end
    s_rspr = 1'b1;
    step();
    check("bp_release_no_grant", 32'(d_acc), 32'd0);
    step();
    check("bp_next_grant", 32'({d_acc, d_acc_id}), 32'b11);
    s_v = '0;
    step(); step();

    // Reset during EXEC aborts the operation
    do_reset();
    s_v = 2'b10; s_a[1] = 16'h7FFF; s_b[1] = 16'h0001; s_code[1] = 5'd0; s_rspr = 1'b1;
    step();
    s_v = '0; s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      check("rst_sticky", 32'(ovf_sticky), 32'd0);
    end
    s_v = 2'b11;
    step();
    check("rst_grant0", 32'({d_acc, d_acc_id}), 32'b10);
    s_v = '0;
    step(); step();

    // Sticky set and clear collide in the same cycle: set wins
    s_v = 2'b01; s_a[0] = 16'h7F00; s_b[0] = 16'h0300; s_code[0] = 5'd0;
    step();
    s_v = '0; s_clr = 2'b01;
    step();
    check("collide_sticky0", 32'(ovf_sticky[0]), 32'd1);
    s_clr = '0;
    step();

    // Randomized traffic with occasional reset and sticky clears
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(0, 199) == 0);
      s_rspr = ($urandom_range(0, 9) < 6);
      s_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int n = 0; n < 2; n++) begin
        if (!s_v[n]) begin
          if ($urandom_range(0, 1) == 0) new_op(n);
        end else if ($urandom_range(0, 19) == 0) begin
          s_v[n] = 1'b0;
        end
      end
      step();
      if (m_acc) s_v[m_acc_id] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
